// File: rtl/two_phase_latch_clock_pkg.sv
// two_phase_pkg: shared FSM state encoding and default counter width for the two-phase latch clock
package two_phase_pkg;
  localparam int CW_DEF = 4;
  typedef enum logic [2:0] {IDLE, PH1, GAP1, PH2, GAP2} state_t;
endpackage

// File: rtl/two_phase_latch_clock_if.sv
// two_phase_latch_clock_if: run/config inputs (en, hi_len, gap_len) and phase outputs (phi1, phi2, frame_done, active)
interface two_phase_latch_clock_if #(parameter int CW = two_phase_pkg::CW_DEF);
  logic en;
  logic [CW-1:0] hi_len;
  logic [CW-1:0] gap_len;
  logic phi1;
  logic phi2;
  logic frame_done;
  logic active;
  modport master(output en, hi_len, gap_len, input phi1, phi2, frame_done, active);
  modport slave(input en, hi_len, gap_len, output phi1, phi2, frame_done, active);
endinterface

// File: rtl/two_phase_latch_clock_phase_counter.sv
// phase_counter: loadable down-counter (ck, rst_n, load, load_val, dec) with zero decoded from the register
module phase_counter #(parameter int CW = 4) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);
  logic [CW-1:0] cnt;
  always_ff @(posedge ck or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec) cnt <= cnt - CW'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/two_phase_latch_clock.sv
// two_phase_latch_clock: non-overlapping phi1/phi2 latch enables from ck; ports ck, rst_n, bus (en, hi_len, gap_len -> phi1, phi2, frame_done, active)
module two_phase_latch_clock import two_phase_pkg::*; #(parameter int CW = CW_DEF) (
  input logic ck,
  input logic rst_n,
  two_phase_latch_clock_if.slave bus
);
  state_t state, nxt;
  logic [CW-1:0] hi_q, gap_q, load_val, eff_hi, eff_gap;
  logic load, dec, zero, start;
  assign eff_hi  = bus.hi_len  == '0 ? CW'(1) : bus.hi_len;
  assign eff_gap = bus.gap_len == '0 ? CW'(1) : bus.gap_len;
  phase_counter #(.CW(CW)) u_cnt (
    .ck      (ck),
    .rst_n   (rst_n),
    .load    (load),
    .load_val(load_val),
    .dec     (dec),
    .zero    (zero)
  );
  always_comb begin
    nxt      = state;
    start    = 1'b0;
    load     = 1'b0;
    dec      = 1'b0;
    load_val = eff_hi - CW'(1);
    case (state)
      IDLE: begin
        start = bus.en;
        load  = bus.en;
        nxt   = bus.en ? PH1 : IDLE;
      end
      PH1: begin
        load     = zero;
        dec      = !zero;
        load_val = gap_q - CW'(1);
        nxt      = zero ? GAP1 : PH1;
      end
      GAP1: begin
        load     = zero;
        dec      = !zero;
        load_val = hi_q - CW'(1);
        nxt      = zero ? PH2 : GAP1;
      end
      PH2: begin
        load     = zero;
        dec      = !zero;
        load_val = gap_q - CW'(1);
        nxt      = zero ? GAP2 : PH2;
      end
      GAP2: begin
        start = zero && bus.en;
        load  = zero && bus.en;
        dec   = !zero;
        nxt   = !zero ? GAP2 : bus.en ? PH1 : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge ck or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      hi_q           <= '0;
      gap_q          <= '0;
      bus.phi1       <= 1'b0;
      bus.phi2       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.active     <= 1'b0;
    end else begin
      state          <= nxt;
      hi_q           <= start ? eff_hi : hi_q;
      gap_q          <= start ? eff_gap : gap_q;
      bus.phi1       <= nxt == PH1;
      bus.phi2       <= nxt == PH2;
      bus.frame_done <= state == GAP2 && zero;
      bus.active     <= nxt != IDLE;
    end
endmodule

// File: tb/tb_two_phase_latch_clock.sv
// tb_two_phase_latch_clock: random and directed stimulus against a frame-level reference model with a scoreboard
module tb_two_phase_latch_clock;
  logic ck = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [3:0] sb[$];
  logic [1:0] frame_q[$];
  logic fd_next = 1'b0;
  two_phase_latch_clock_if #(.CW(4)) bus();
  two_phase_latch_clock #(.CW(4)) dut (.ck(ck), .rst_n(rst_n), .bus(bus));
  always #5 ck = ~ck;
  always @(posedge ck) begin
    logic [3:0] e;
    int h, g;
    if (!rst_n) begin
      frame_q.delete();
      fd_next = 1'b0;
      sb.push_back(4'b0000);
    end else begin
      e = {2'b00, fd_next, 1'b0};
      fd_next = 1'b0;
      if (frame_q.size() == 0 && bus.en) begin
        h = bus.hi_len == 0 ? 1 : int'(bus.hi_len);
        g = bus.gap_len == 0 ? 1 : int'(bus.gap_len);
        for (int i = 0; i < h; i++) frame_q.push_back(2'b10);
        for (int i = 0; i < g; i++) frame_q.push_back(2'b00);
        for (int i = 0; i < h; i++) frame_q.push_back(2'b01);
        for (int i = 0; i < g; i++) frame_q.push_back(2'b00);
      end
      if (frame_q.size() != 0) begin
        e[3:2] = frame_q.pop_front();
        e[0] = 1'b1;
        if (frame_q.size() == 0) fd_next = 1'b1;
      end
      sb.push_back(e);
    end
  end
  always @(posedge ck) begin
    logic [3:0] got, exp_v;
    #1;
    got = {bus.phi1, bus.phi2, bus.frame_done, bus.active};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty t=%0t got=%b", $time, got);
    end else begin
      exp_v = sb.pop_front();
      if (got !== exp_v) begin
        errors++;
        $display("FAIL outputs t=%0t {phi1,phi2,frame_done,active} got=%b exp=%b", $time, got, exp_v);
      end
    end
  end
  always @(negedge ck) begin
    checks++;
    if (bus.phi1 & bus.phi2) begin
      errors++;
      $display("FAIL overlap t=%0t phi1=%b phi2=%b exp=not both 1", $time, bus.phi1, bus.phi2);
    end
  end
  task automatic drive(input logic e, input int h, input int g, input int n);
    repeat (n) begin
      @(negedge ck);
      bus.en = e;
      bus.hi_len = 4'(h);
      bus.gap_len = 4'(g);
    end
  endtask
  initial begin
    bus.en = 1'b0;
    bus.hi_len = 4'd0;
    bus.gap_len = 4'd0;
    repeat (3) @(negedge ck);
    rst_n = 1'b1;
    drive(1, 2, 1, 14);
    drive(0, 2, 1, 8);
    drive(1, 0, 0, 1);
    drive(0, 0, 0, 8);
    drive(1, 3, 2, 6);
    drive(0, 3, 2, 14);
    drive(1, 2, 1, 3);
    drive(1, 5, 1, 10);
    drive(0, 5, 1, 20);
    drive(1, 4, 2, 2);
    @(posedge ck);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.phi1, bus.phi2, bus.frame_done, bus.active} !== 4'b0000) begin
      errors++;
      $display("FAIL async_reset got=%b exp=0000", {bus.phi1, bus.phi2, bus.frame_done, bus.active});
    end
    drive(1, 4, 2, 2);
    rst_n = 1'b1;
    drive(1, 2, 3, 16);
    for (int i = 0; i < 10000; i++)
      drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1);
    drive(0, 0, 0, 70);
    checks++;
    if (bus.active !== 1'b0) begin
      errors++;
      $display("FAIL drain_idle active got=%b exp=0", bus.active);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
